// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter: accept -> access -> response pipeline.
// Macro DMEM_ARB_RR_EN selects round-robin ties; undefined gives fixed priority to port 0.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    dmem_arbiter_if.slave   bus
);
    logic w_gnt0;
    logic w_gnt1;

`ifdef DMEM_ARB_RR_EN
    logic r_last;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
`else
                w_gnt0 = 1'b1;
`endif
            end else begin
                w_gnt0 = bus.m0_req;
                w_gnt1 = bus.m1_req;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (w_gnt0)
            r_last <= 1'b0;
        else if (w_gnt1)
            r_last <= 1'b1;
    end
`endif

    logic              r_valid;
    logic              r_we;
    logic              r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_valid <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_we    <= bus.m0_we;
                r_id    <= 1'b0;
                r_addr  <= bus.m0_addr;
                r_wdata <= bus.m0_wdata;
            end else if (w_gnt1) begin
                r_we    <= bus.m1_we;
                r_id    <= 1'b1;
                r_addr  <= bus.m1_addr;
                r_wdata <= bus.m1_wdata;
            end
        end
    end

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_rd_access;

    assign w_rd_access = r_valid && !r_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_rd_access && !r_id;
            r_rvalid1 <= w_rd_access && r_id;
            if (w_rd_access && !r_id)
                r_rdata0 <= bus.mem_rdata;
            if (w_rd_access && r_id)
                r_rdata1 <= bus.mem_rdata;
        end
    end

    // A write sitting in the access stage when reset arrives must not reach memory.
    assign bus.mem_we    = r_valid && r_we && !rst;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed plus randomized bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] mem_arr [16];

    assign bus.m0_req    = req[0];
    assign bus.m0_we     = we[0];
    assign bus.m0_addr   = addr[0];
    assign bus.m0_wdata  = wdata[0];
    assign bus.m1_req    = req[1];
    assign bus.m1_we     = we[1];
    assign bus.m1_addr   = addr[1];
    assign bus.m1_wdata  = wdata[1];
    assign bus.mem_rdata = mem_arr[bus.mem_addr[5:2]];

    typedef struct {
        int          gc;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         ops [$];
    logic [31:0] mm [16];
    logic [1:0]  erv;
    logic [31:0] erd [2];
    logic [31:0] emaddr;
    logic [31:0] emwd;
    logic        last_p;
    logic [1:0]  obs_g;
    int          cyc;
    int          total;
    int          bad;
    logic        auto_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle();
        logic        eg0;
        logic        eg1;
        logic        has;
        logic        emwe;
        logic        wp;
        logic [3:0]  wi;
        logic [31:0] wd;
        logic [1:0]  nrv;
        op_t         op;
        op_t         nop;
        @(negedge clk);
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            if (req[0] && req[1]) begin
`ifdef DMEM_ARB_RR_EN
                if (last_p) eg0 = 1'b1;
                else        eg1 = 1'b1;
`else
                eg0 = 1'b1;
`endif
            end else begin
                eg0 = req[0];
                eg1 = req[1];
            end
        end
        has = 1'b0;
        if (ops.size() > 0)
            has = (ops[0].gc == cyc - 1);
        emwe = !rst && has && ops[0].we;
        chk("m0_gnt", {31'd0, bus.m0_gnt}, {31'd0, eg0});
        chk("m1_gnt", {31'd0, bus.m1_gnt}, {31'd0, eg1});
        if (cyc > 0) begin
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, emwe});
            chk("mem_addr", bus.mem_addr, emaddr);
            chk("mem_wdata", bus.mem_wdata, emwd);
            chk("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, erv[0]});
            chk("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, erv[1]});
            chk("m0_rdata", bus.m0_rdata, erd[0]);
            chk("m1_rdata", bus.m1_rdata, erd[1]);
        end
        obs_g = {bus.m1_gnt, bus.m0_gnt};
        wp = bus.mem_we;
        wi = bus.mem_addr[5:2];
        wd = bus.mem_wdata;

        @(posedge clk);
        if (wp === 1'b1)
            mem_arr[wi] = wd;
        if (has)
            op = ops.pop_front();
        nrv = 2'b00;
        if (!rst) begin
            if (has) begin
                if (op.we)
                    mm[op.addr[5:2]] = op.data;
                else begin
                    nrv[op.port] = 1'b1;
                    erd[op.port] = mm[op.addr[5:2]];
                end
            end
            if (eg0 || eg1) begin
                nop.gc   = cyc;
                nop.port = eg1;
                nop.we   = we[eg1];
                nop.addr = addr[eg1];
                nop.data = wdata[eg1];
                ops.push_back(nop);
                emaddr = nop.addr;
                emwd   = nop.data;
                last_p = eg1;
            end
        end else begin
            ops.delete();
            erd[0] = '0;
            erd[1] = '0;
            emaddr = '0;
            emwd   = '0;
            last_p = 1'b1;
        end
        erv = nrv;
        cyc++;

        #1;
        if (auto_en) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || obs_g[p]) begin
                    if ($urandom_range(3) != 0) begin
                        req[p]   = 1'b1;
                        we[p]    = 1'($urandom_range(1));
                        addr[p]  = 32'($urandom_range(15)) << 2;
                        wdata[p] = $urandom;
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
            rst = ($urandom_range(39) == 0);
        end
    endtask

    task automatic issue(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        do begin
            run_cycle();
            n++;
        end while (!obs_g[p] && n < 8);
        chk("issue_gnt", {31'd0, obs_g[p]}, 32'd1);
        req[p] = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        auto_en = 1'b0;
        last_p  = 1'b1;
        erv     = 2'b00;
        erd[0]  = '0;
        erd[1]  = '0;
        emaddr  = '0;
        emwd    = '0;
        obs_g   = 2'b00;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = 32'h1000_0000 + 32'(i);
            mm[i]      = 32'h1000_0000 + 32'(i);
        end
        we       = 2'b00;
        addr[0]  = 32'h0;
        addr[1]  = 32'h4;
        wdata[0] = '0;
        wdata[1] = '0;

        // Reset held two cycles with both requesters asking.
        rst = 1'b1;
        req = 2'b11;
        run_cycle();
        run_cycle();
        chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        chk("rst_rdata0", bus.m0_rdata, 32'd0);
        rst = 1'b0;

        // Contention: both ports reading continuously.
        for (int i = 0; i < 6; i++) begin
            run_cycle();
`ifdef DMEM_ARB_RR_EN
            chk("cont_g0", {31'd0, obs_g[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
`else
            chk("cont_g0", {31'd0, obs_g[0]}, 32'd1);
`endif
        end
        req[0] = 1'b0;
        run_cycle();
        chk("cont_m1_after_drop", {31'd0, obs_g[1]}, 32'd1);
        req[1] = 1'b0;
        run_cycle();
        run_cycle();

        // Single write then read on port 0.
        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        run_cycle();
        chk("wr_rd_rvalid0", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("wr_rd_rdata0", bus.m0_rdata, 32'hDEAD_BEEF);
        chk("wr_rd_rvalid1", {31'd0, bus.m1_rvalid}, 32'd0);
        run_cycle();

        // Read-after-write across ports in consecutive grants.
        issue(1'b1, 1'b1, 32'h20, 32'h5);
        issue(1'b0, 1'b0, 32'h20, 32'h0);
        run_cycle();
        chk("raw_rdata0", bus.m0_rdata, 32'h5);
        run_cycle();

        // Reset right after a write grant cancels that write.
        issue(1'b0, 1'b1, 32'h30, 32'h7);
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        chk("mid_rst_mem", mem_arr[12], 32'h1000_000C);
        issue(1'b0, 1'b0, 32'h30, 32'h0);
        run_cycle();
        chk("mid_rst_rdata0", bus.m0_rdata, 32'h1000_000C);
        run_cycle();

        // Randomized traffic with occasional resets.
        auto_en = 1'b1;
        repeat (400) run_cycle();
        auto_en = 1'b0;
        rst = 1'b0;
        req = 2'b00;
        repeat (3) run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
